ac3_quant_ctrl: RTL and testbench

//  Downstream stage of the four AC3 output accumulator registers.

---
 rtl/ac3_quant_ctrl.sv | 130 +++++++++++++
 tb/tb_ac3_quant_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac3_quant_ctrl.sv
// rtl/ac3_quant_ctrl.sv - AC3 accumulator quantization: shift, saturate/ReLU, stream out, clear
module ac3_quant_ctrl #(
    parameter  int M   = 16,
    parameter  int Pa  = 8,
    parameter  int Pw  = 8,
    parameter  int MNO = 288,
    parameter  int NL  = 4,
    localparam int AW  = $clog2(M) + Pa + Pw + $clog2(MNO),
    localparam int SW  = $clog2(AW),
    localparam int LW  = $clog2(NL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SW-1:0]    shamt_i,
    input  logic             relu_en_i,
    input  logic [NL*AW-1:0] acc_in_i,
    output logic             s_en_o,
    output logic             cl_en_o,
    output logic [Pa-1:0]    out_data_o,
    output logic [LW-1:0]    out_lane_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_OUT,
        ST_CLEAR
    } state_t;

    // Saturation bounds as AW-bit signed values; the minimum is the bitwise inverse of the maximum.
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (Pa - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          relu_q, relu_d;

    logic signed [AW-1:0] lane_val;

    function automatic logic [Pa-1:0] sat(input logic signed [AW-1:0] x, input logic relu);
        if (relu && x[AW-1]) begin
            return '0;
        end else if (x > SAT_MAX) begin
            return SAT_MAX[Pa-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[Pa-1:0];
        end else begin
            return x[Pa-1:0];
        end
    endfunction

    // Accumulator of the lane currently being presented; the registers are not shifted during OUT, so it is stable.
    assign lane_val = $signed(acc_in_i[lane_q*AW +: AW]);

    // State, shift counter, lane index and latched ReLU mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            relu_q  <= relu_d;
        end
    end

    // Next-state logic and Moore outputs decoded from the registered state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        relu_d      = relu_q;
        s_en_o      = 1'b0;
        cl_en_o     = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_lane_o  = '0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    cnt_d   = shamt_i;
                    relu_d  = relu_en_i;
                    lane_d  = '0;
                    state_d = (shamt_i != '0) ? ST_SHIFT : ST_OUT;
                end
            end
            ST_SHIFT: begin
                s_en_o = 1'b1;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid_o = 1'b1;
                out_data_o  = sat(lane_val, relu_q);
                out_lane_o  = lane_q;
                if (out_ready_i) begin
                    if (lane_q == LW'(NL - 1)) begin
                        lane_d  = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                cl_en_o = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ac3_quant_ctrl.sv
// tb/tb_ac3_quant_ctrl.sv - scoreboard bench for ac3_quant_ctrl with a behavioural AC3 register model
module tb_ac3_quant_ctrl;

    localparam int NL = 4;
    localparam int AW = 29;
    localparam int SW = 5;
    localparam int LW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [SW-1:0]    shamt_i = '0;
    logic             relu_en_i = 1'b0;
    logic [NL*AW-1:0] acc_in;
    logic             s_en_o, cl_en_o, out_valid_o, busy_o, done_o;
    logic [7:0]       out_data_o;
    logic [LW-1:0]    out_lane_o;
    logic             out_ready_i = 1'b1;

    ac3_quant_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .shamt_i     (shamt_i),
        .relu_en_i   (relu_en_i),
        .acc_in_i    (acc_in),
        .s_en_o      (s_en_o),
        .cl_en_o     (cl_en_o),
        .out_data_o  (out_data_o),
        .out_lane_o  (out_lane_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // AC3 register model: load, arithmetic shift by one on s_en, clear on cl_en.
    logic signed [AW-1:0] ac3 [NL];
    int  load_val [NL];
    bit  load = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NL; k++) ac3[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NL; k++) ac3[k] <= AW'(load_val[k]);
        end else if (cl_en_o) begin
            for (int k = 0; k < NL; k++) ac3[k] <= '0;
        end else if (s_en_o) begin
            for (int k = 0; k < NL; k++) ac3[k] <= ac3[k] >>> 1;
        end
    end

    always_comb begin
        acc_in = '0;
        for (int k = 0; k < NL; k++) acc_in[k*AW +: AW] = ac3[k];
    end

    int checks = 0;
    int errors = 0;
    int exp_lane_q [$];
    int exp_data_q [$];

    int sen_cnt = 0, cl_cnt = 0, done_cnt = 0, hs_cnt = 0, overlap_cnt = 0;
    int done_cyc = 0, rise_cyc = 0, stall_cnt = 0;
    int ready_mode = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_ref(input int v, input int sh, input bit relu);
        longint x;
        x = longint'(v) >>> sh;
        if (relu && x < 0) return 0;
        if (x > 127) return 127;
        if (x < -128) return -128;
        return int'(x);
    endfunction

    task automatic monitor();
        bit prev_valid = 1'b0;
        bit prev_stall = 1'b0;
        int prev_data = 0, prev_lane = 0, d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (s_en_o) sen_cnt++;
                if (cl_en_o) cl_cnt++;
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if ((s_en_o && cl_en_o) || (s_en_o && out_valid_o)) overlap_cnt++;
                if (out_valid_o && !prev_valid) rise_cyc = cyc;
                d = int'($signed(out_data_o));
                if (out_valid_o && prev_stall) begin
                    chk_eq("stall_data", d, prev_data);
                    chk_eq("stall_lane", int'(out_lane_o), prev_lane);
                end
                if (out_valid_o && out_ready_i) begin
                    hs_cnt++;
                    if (exp_data_q.size() == 0) begin
                        chk_eq("extra_handshake", 1, 0);
                    end else begin
                        chk_eq("lane", int'(out_lane_o), exp_lane_q.pop_front());
                        chk_eq("data", d, exp_data_q.pop_front());
                    end
                end
                prev_valid = out_valid_o;
                prev_stall = out_valid_o && !out_ready_i;
                prev_data  = d;
                prev_lane  = int'(out_lane_o);
            end
        end
    endtask

    // Consumer: always ready, or five stall cycles on lane 1 plus random stalls elsewhere.
    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                out_ready_i = 1'b1;
                stall_cnt = 0;
            end else if (out_valid_o && out_lane_o == LW'(1) && stall_cnt < 5) begin
                out_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                out_ready_i = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic load_regs(input int v [NL]);
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) load_val[k] = v[k];
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run_op(input string tag, input int v [NL], input int sh, input bit relu,
                          input int e [NL], input int mode, input bit noise);
        int b_sen, b_hs, b_cl, b_done, start_edge, busy_drop, n;
        bit got;
        ready_mode = mode;
        load_regs(v);
        for (int k = 0; k < NL; k++) begin
            exp_lane_q.push_back(k);
            exp_data_q.push_back(e[k]);
        end
        b_sen = sen_cnt; b_hs = hs_cnt; b_cl = cl_cnt; b_done = done_cnt;
        start_i = 1'b1;
        shamt_i = SW'(sh);
        relu_en_i = relu;
        start_edge = cyc + 1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk_eq({tag, "_busy_start"}, int'(busy_o), 1);
        got = 1'b0;
        busy_drop = 0;
        n = 0;
        while (!got && n < 300) begin
            if (done_o) begin
                got = 1'b1;
            end else begin
                if (!busy_o) busy_drop++;
                if (noise && $urandom_range(0, 2) == 0) begin
                    start_i = 1'b1;
                    shamt_i = SW'($urandom_range(0, 31));
                    relu_en_i = 1'($urandom_range(0, 1));
                end else begin
                    start_i = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
        end
        start_i = 1'b0;
        chk_eq({tag, "_done_timeout"}, int'(got), 1);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_eq({tag, "_busy_after"}, int'(busy_o), 0);
        chk_eq({tag, "_busy_drop"}, busy_drop, 0);
        chk_eq({tag, "_s_en_cycles"}, sen_cnt - b_sen, sh);
        chk_eq({tag, "_handshakes"}, hs_cnt - b_hs, NL);
        chk_eq({tag, "_cl_en_cycles"}, cl_cnt - b_cl, 1);
        chk_eq({tag, "_done_pulses"}, done_cnt - b_done, 1);
        chk_eq({tag, "_sb_left"}, exp_data_q.size(), 0);
        chk_eq({tag, "_overlap"}, overlap_cnt, 0);
        chk_eq({tag, "_first_valid"}, rise_cyc - start_edge, sh);
        if (mode == 0) chk_eq({tag, "_done_latency"}, done_cyc - start_edge, sh + NL);
        if (mode != 0) chk_eq({tag, "_lane1_stalls"}, stall_cnt, 5);
        for (int k = 0; k < NL; k++) chk_eq({tag, "_cleared"}, int'(ac3[k]), 0);
    endtask

    int v [NL];
    int e [NL];
    int sh;
    bit rl;

    initial begin
        fork
            monitor();
            ready_driver();
        join_none

        #1;
        chk_eq("rst_s_en", int'(s_en_o), 0);
        chk_eq("rst_cl_en", int'(cl_en_o), 0);
        chk_eq("rst_valid", int'(out_valid_o), 0);
        chk_eq("rst_busy", int'(busy_o), 0);
        chk_eq("rst_done", int'(done_o), 0);
        chk_eq("rst_data", int'(out_data_o), 0);
        chk_eq("rst_lane", int'(out_lane_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        v = '{1000, -1000, 50, -5};    e = '{125, -125, 6, -1};
        run_op("t1", v, 3, 1'b0, e, 0, 1'b0);

        v = '{300, -300, 127, -128};   e = '{127, -128, 127, -128};
        run_op("t2", v, 0, 1'b0, e, 0, 1'b0);

        v = '{-64, 64, -2, 255};       e = '{0, 32, 0, 127};
        run_op("t3", v, 1, 1'b1, e, 0, 1'b0);

        v = '{-5000, 5000, -200000, 200000};
        for (int k = 0; k < NL; k++) e[k] = sat_ref(v[k], 30, 1'b0);
        run_op("t_bigshift", v, 30, 1'b0, e, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NL; k++) v[k] = int'($urandom_range(0, 400000)) - 200000;
            sh = int'($urandom_range(0, 12));
            rl = 1'($urandom_range(0, 1));
            for (int k = 0; k < NL; k++) e[k] = sat_ref(v[k], sh, rl);
            run_op("t4", v, sh, rl, e, 1, 1'b0);
        end

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NL; k++) v[k] = int'($urandom_range(0, 40000)) - 20000;
            sh = int'($urandom_range(1, 9));
            rl = 1'($urandom_range(0, 1));
            for (int k = 0; k < NL; k++) e[k] = sat_ref(v[k], sh, rl);
            run_op("t5", v, sh, rl, e, r % 2, 1'b1);
        end

        ready_mode = 0;
        v = '{4000, -4000, 900, -900};
        load_regs(v);
        start_i = 1'b1;
        shamt_i = SW'(6);
        relu_en_i = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("t6_in_shift", int'(s_en_o), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_s_en", int'(s_en_o), 0);
        chk_eq("t6_cl_en", int'(cl_en_o), 0);
        chk_eq("t6_valid", int'(out_valid_o), 0);
        chk_eq("t6_busy", int'(busy_o), 0);
        chk_eq("t6_done", int'(done_o), 0);
        chk_eq("t6_data", int'(out_data_o), 0);
        exp_lane_q.delete();
        exp_data_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{-700, 700, 33, -33};
        for (int k = 0; k < NL; k++) e[k] = sat_ref(v[k], 2, 1'b1);
        run_op("t6", v, 2, 1'b1, e, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
